// File: rtl/ray_slab_combine_pkg.sv
// Float word layout and FSM encoding shared by the slab-combine stage and its bus.
package ray_slab_combine_pkg;

    localparam int FLT_W  = 27;
    localparam int EXN_HI = FLT_W;
    localparam int EXN_LO = FLT_W - 1;
    localparam int SIGN   = FLT_W - 2;

    localparam logic [1:0] EXN_NORMAL = 2'b01;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CMP_NEAR  = 3'd1;
    localparam logic [2:0] ST_CMP_FAR   = 3'd2;
    localparam logic [2:0] ST_CMP_FINAL = 3'd3;
    localparam logic [2:0] ST_EMIT      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        CMP_NEAR  = ST_CMP_NEAR,
        CMP_FAR   = ST_CMP_FAR,
        CMP_FINAL = ST_CMP_FINAL,
        EMIT      = ST_EMIT
    } state_t;

endpackage

// File: rtl/ray_slab_combine_if.sv
// Axis input, result output and shared-comparator signals of the slab-combine stage.
interface ray_slab_combine_if
    import ray_slab_combine_pkg::*;
#(
    parameter int WIDTH = FLT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_near;
    logic [WIDTH:0]   in_far;
    logic             in_last;
    logic [WIDTH:0]   cmp_a;
    logic [WIDTH:0]   cmp_b;
    logic             cmp_less;
    logic             out_valid;
    logic             out_ready;
    logic             out_hit;
    logic [WIDTH:0]   out_tnear;
    logic [WIDTH:0]   out_tfar;

    modport slave (
        input  in_valid, in_near, in_far, in_last, cmp_less, out_ready,
        output in_ready, cmp_a, cmp_b, out_valid, out_hit, out_tnear, out_tfar
    );

    modport master (
        output in_valid, in_near, in_far, in_last, cmp_less, out_ready,
        input  in_ready, cmp_a, cmp_b, out_valid, out_hit, out_tnear, out_tfar
    );
endinterface

// File: rtl/ray_slab_combine.sv
// Reduces one ray's per-axis slab intervals to max(tnear)/min(tfar) through a shared
// external less-than comparator, then reports entry/exit distances and a hit flag.
module ray_slab_combine
    import ray_slab_combine_pkg::*;
#(
    parameter int WIDTH   = FLT_W,
    parameter int CMP_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    ray_slab_combine_if.slave bus
);
    localparam int CNT_W = $clog2(CMP_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMP_LAT - 1);

    typedef logic [WIDTH:0] word_t;

    function automatic logic is_neg_normal(input word_t w);
        return (w[EXN_HI:EXN_LO] == EXN_NORMAL) && w[SIGN];
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             hit_q, hit_d;
    word_t            cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    word_t            tnear_q, tnear_d, tfar_q, tfar_d;
    word_t            acc_near_q, acc_near_d, acc_far_q, acc_far_d;
    word_t            lat_near_q, lat_near_d, lat_far_q, lat_far_d;
    word_t            far_upd;
    logic             cmp_done;
    logic             accept;

    assign cmp_done = (cnt_q == CNT_LAST);
    assign accept   = bus.in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        last_d     = last_q;
        hit_d      = hit_q;
        cmp_a_d    = cmp_a_q;
        cmp_b_d    = cmp_b_q;
        tnear_d    = tnear_q;
        tfar_d     = tfar_q;
        acc_near_d = acc_near_q;
        acc_far_d  = acc_far_q;
        lat_near_d = lat_near_q;
        lat_far_d  = lat_far_q;
        far_upd    = acc_far_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (first_q) begin
                        acc_near_d = bus.in_near;
                        acc_far_d  = bus.in_far;
                        if (bus.in_last) begin
                            // A one-axis ray goes straight to the far-vs-near ordering check.
                            cmp_a_d = bus.in_far;
                            cmp_b_d = bus.in_near;
                            cnt_d   = '0;
                            state_d = CMP_FINAL;
                        end else begin
                            first_d = 1'b0;
                        end
                    end else begin
                        lat_near_d = bus.in_near;
                        lat_far_d  = bus.in_far;
                        last_d     = bus.in_last;
                        cmp_a_d    = acc_near_q;
                        cmp_b_d    = bus.in_near;
                        cnt_d      = '0;
                        state_d    = CMP_NEAR;
                    end
                end
            end
            CMP_NEAR: begin
                if (cmp_done) begin
                    if (bus.cmp_less) acc_near_d = lat_near_q;
                    cmp_a_d = lat_far_q;
                    cmp_b_d = acc_far_q;
                    cnt_d   = '0;
                    state_d = CMP_FAR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CMP_FAR: begin
                if (cmp_done) begin
                    far_upd   = bus.cmp_less ? lat_far_q : acc_far_q;
                    acc_far_d = far_upd;
                    cnt_d     = '0;
                    if (last_q) begin
                        cmp_a_d = far_upd;
                        cmp_b_d = acc_near_q;
                        state_d = CMP_FINAL;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CMP_FINAL: begin
                if (cmp_done) begin
                    // Zero tfar carries exception 00, so it never counts as negative.
                    hit_d   = !bus.cmp_less && !is_neg_normal(acc_far_q);
                    tnear_d = acc_near_q;
                    tfar_d  = acc_far_q;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    first_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            tnear_q     <= '0;
            tfar_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            last_q      <= last_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            hit_q       <= hit_d;
            cmp_a_q     <= cmp_a_d;
            cmp_b_q     <= cmp_b_d;
            tnear_q     <= tnear_d;
            tfar_q      <= tfar_d;
        end
    end

    // Accumulators are always rewritten by a ray's first axis before being read.
    always_ff @(posedge clk) begin
        acc_near_q <= acc_near_d;
        acc_far_q  <= acc_far_d;
        lat_near_q <= lat_near_d;
        lat_far_q  <= lat_far_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hit   = hit_q;
    assign bus.out_tnear = tnear_q;
    assign bus.out_tfar  = tfar_q;
    assign bus.cmp_a     = cmp_a_q;
    assign bus.cmp_b     = cmp_b_q;

endmodule
